ifu_fetch_stage: RTL and testbench

- Instruction-fetch stage placed directly upstream of the combinational decoder.
- Issues in-order fetch requests to instruction memory and buffers the returned words with their PCs in a small FIFO.
- Presents one {instr, pc} pair per cycle to the decode stage over a valid/ready handshake.
- Handles redirects from the execute stage (jal/jalr/branch): flushes the buffer and discards any in-flight responses.

---
 rtl/ifu_fetch_stage_if.sv | 28 ++
 rtl/ifu_fetch_stage.sv | 150 +++++++++++++++
 tb/tb_ifu_fetch_stage.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ifu_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handshake and redirect.
// master = fetch stage, slave = memory/decoder/execute side.
interface ifu_fetch_stage_if #(
  parameter int unsigned XLEN = 64
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            halted;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, halted,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_instr, id_pc, halted,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifu_fetch_stage.sv
// In-order instruction fetch with a credit-limited response FIFO feeding decode.
// Optional IFU_EBREAK_HALT_EN: stop fetching after an ebreak is buffered until redirect.
module ifu_fetch_stage #(
  parameter int unsigned     XLEN      = 64,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(64'h8000_0000),
  parameter int unsigned     BUF_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  ifu_fetch_stage_if.master   bus
);
  localparam int unsigned    PW      = $clog2(BUF_DEPTH);
  localparam int unsigned    CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(BUF_DEPTH);
`ifdef IFU_EBREAK_HALT_EN
  localparam logic [31:0]    EBREAK  = 32'h0010_0073;
`endif

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN
`ifdef IFU_EBREAK_HALT_EN
    , ST_HALT
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [31:0]     instr_q [BUF_DEPTH];
  logic [31:0]     instr_d [BUF_DEPTH];
  logic [XLEN-1:0] pc_buf_q [BUF_DEPTH];
  logic [XLEN-1:0] pc_buf_d [BUF_DEPTH];
`ifdef IFU_EBREAK_HALT_EN
  logic            halted_q, halted_d;
`endif

  logic            req_valid, fire, rsp, id_valid, pop, push;
  logic [XLEN-1:0] redirect_tgt;

  // Credit counts buffered entries plus every in-flight request, including ones to be discarded.
  assign req_valid    = (state_q == ST_RUN)
                      && (({1'b0, count_q} + {1'b0, outstanding_q}) < {1'b0, DEPTH_C})
                      && !bus.redirect_valid;
  assign fire         = req_valid && bus.imem_req_ready;
  assign rsp          = bus.imem_rsp_valid;
  assign id_valid     = (count_q != '0);
  assign pop          = id_valid && bus.id_ready;
  assign push         = rsp && (discard_q == '0) && !bus.redirect_valid;
  assign redirect_tgt = bus.redirect_pc & ~XLEN'(3);

  always_comb begin
    state_d       = state_q;
    req_pc_d      = req_pc_q;
    rsp_pc_d      = rsp_pc_q;
    discard_d     = discard_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    instr_d       = instr_q;
    pc_buf_d      = pc_buf_q;
`ifdef IFU_EBREAK_HALT_EN
    halted_d      = halted_q;
`endif
    outstanding_d = outstanding_q + CW'(fire) - CW'(rsp);

    if (state_q == ST_BOOT) state_d = ST_RUN;
    if (fire) req_pc_d = req_pc_q + XLEN'(4);

    if (bus.redirect_valid) begin
      // Everything still in flight after this cycle's response belongs to the old path.
      discard_d = outstanding_q - CW'(rsp);
      count_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      req_pc_d  = redirect_tgt;
      rsp_pc_d  = redirect_tgt;
      state_d   = ST_RUN;
`ifdef IFU_EBREAK_HALT_EN
      halted_d  = 1'b0;
`endif
    end else begin
      if (rsp && (discard_q != '0)) discard_d = discard_q - CW'(1);
      if (push) begin
        instr_d[wr_ptr_q]  = bus.imem_rsp_data;
        pc_buf_d[wr_ptr_q] = rsp_pc_q;
        wr_ptr_d           = wr_ptr_q + PW'(1);
        rsp_pc_d           = rsp_pc_q + XLEN'(4);
`ifdef IFU_EBREAK_HALT_EN
        if (bus.imem_rsp_data == EBREAK) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end
`endif
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      req_pc_q      <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      instr_q       <= '{default: '0};
      pc_buf_q      <= '{default: '0};
`ifdef IFU_EBREAK_HALT_EN
      halted_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      req_pc_q      <= req_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      instr_q       <= instr_d;
      pc_buf_q      <= pc_buf_d;
`ifdef IFU_EBREAK_HALT_EN
      halted_q      <= halted_d;
`endif
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && !pop && (count_q == DEPTH_C)));

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = req_pc_q;
  assign bus.id_valid       = id_valid;
  assign bus.id_instr       = instr_q[rd_ptr_q];
  assign bus.id_pc          = pc_buf_q[rd_ptr_q];
`ifdef IFU_EBREAK_HALT_EN
  assign bus.halted         = halted_q;
`else
  assign bus.halted         = 1'b0;
`endif
endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Randomized bench for ifu_fetch_stage against a queue-based model of memory and the decode stream.
module tb_ifu_fetch_stage;
  localparam int unsigned XLEN   = 64;
  localparam int unsigned DEPTH  = 2;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ifu_fetch_stage_if #(.XLEN(XLEN)) bus ();

  ifu_fetch_stage #(.XLEN(XLEN), .RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct { logic [63:0] addr; int unsigned epoch; int unsigned due; } req_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } ent_t;

  req_t        pend[$];
  ent_t        fifo_m[$];
  int unsigned n_vec = 0, n_err = 0;
  int unsigned cyc = 0, epoch = 0, lat = 1, p_rr = 100, p_ir = 100;
  logic [63:0] exp_req = RST_PC;
  logic [63:0] ebreak_addr = '1;
  bit          halt_m = 1'b0;
  bit          did;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == ebreak_addr) return EBREAK;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0001;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, compare shortly after, then advance the model for the coming edge.
  task automatic step(input int rmode, input logic [63:0] tgt, output bit rdr);
    bit   rr, ir, rspv, drop, exp_rv;
    req_t h;
    @(negedge clk);
    rr   = ($urandom_range(99) < p_rr);
    ir   = ($urandom_range(99) < p_ir);
    rspv = (pend.size() > 0) && (pend[0].due <= cyc);
    rdr  = (rmode == 1) || ((rmode == 2) && rspv && (fifo_m.size() > 0));
    if (rdr && rmode == 2) ir = 1'b1;
    bus.imem_req_ready = rr;
    bus.id_ready       = ir;
    bus.imem_rsp_valid = rspv;
    bus.imem_rsp_data  = rspv ? mem_word(pend[0].addr) : 32'($urandom);
    bus.redirect_valid = rdr;
    bus.redirect_pc    = rdr ? tgt : {32'($urandom), 32'($urandom)};
    #1;
    exp_rv = !halt_m && ((fifo_m.size() + pend.size()) < DEPTH) && !rdr;
    check("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
    if (bus.imem_req_valid && exp_rv) check("req_addr", bus.imem_req_addr, exp_req);
    check("id_valid", 64'(bus.id_valid), 64'(fifo_m.size() > 0));
    if (bus.id_valid && fifo_m.size() > 0) begin
      check("id_pc", bus.id_pc, fifo_m[0].pc);
      check("id_instr", 64'(bus.id_instr), 64'(fifo_m[0].instr));
    end
    check("halted", 64'(bus.halted), 64'(halt_m));

    if (bus.imem_req_valid && rr) begin
      pend.push_back('{addr: bus.imem_req_addr, epoch: epoch, due: cyc + lat});
      exp_req += 64'd4;
    end
    drop = 1'b1;
    if (rspv) begin
      h    = pend.pop_front();
      drop = rdr || (h.epoch != epoch);
    end
    if (rdr) begin
      fifo_m.delete();
      epoch++;
      exp_req = tgt & ~64'h3;
      halt_m  = 1'b0;
    end else begin
      if (ir && fifo_m.size() > 0) void'(fifo_m.pop_front());
      if (rspv && !drop) begin
        fifo_m.push_back('{pc: h.addr, instr: mem_word(h.addr)});
`ifdef IFU_EBREAK_HALT_EN
        if (mem_word(h.addr) == EBREAK) halt_m = 1'b1;
`endif
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run(input int unsigned n);
    bit r;
    for (int unsigned i = 0; i < n; i++) step(0, '0, r);
  endtask

  task automatic wait_pending(input int unsigned want, input string tag);
    bit r;
    int unsigned k = 0;
    while (pend.size() != want && k < 40) begin
      step(0, '0, r);
      k++;
    end
    check(tag, 64'(pend.size()), 64'(want));
  endtask

  // Reset is asserted away from any clock edge so the outputs must clear asynchronously.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n              = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.id_ready       = 1'b0;
    bus.imem_req_ready = 1'b0;
    #1;
    check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    check("rst_id_valid", 64'(bus.id_valid), 64'd0);
    check("rst_halted", 64'(bus.halted), 64'd0);
    check("rst_req_addr", bus.imem_req_addr, RST_PC);
    check("rst_id_pc", bus.id_pc, 64'd0);
    check("rst_id_instr", 64'(bus.id_instr), 64'd0);
    pend.delete();
    fifo_m.delete();
    epoch++;
    exp_req = RST_PC;
    halt_m  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("boot_idle", 64'(bus.imem_req_valid), 64'd0);
  endtask

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Streaming from reset with 1-cycle memory.
    do_reset();
    lat = 1; p_rr = 100; p_ir = 100;
    run(30);

    // Decode backpressure then release.
    p_ir = 0;
    run(10);
    p_ir = 100;
    run(20);

    // Redirect with two slow responses in flight.
    lat = 3;
    wait_pending(2, "two_outstanding");
    step(1, 64'h8000_1002, did);
    run(20);

    // Redirect coinciding with a response and a pop.
    lat = 1; p_ir = 50;
    did = 1'b0;
    for (int unsigned i = 0; i < 60 && !did; i++) step(2, 64'h8000_2000, did);
    check("coincident_redirect_seen", 64'(did), 64'd1);
    p_ir = 100;
    run(20);

    // Randomized traffic, latencies and redirects.
    p_rr = 70; p_ir = 60;
    for (int unsigned blk = 0; blk < 12; blk++) begin
      lat = $urandom_range(4, 1);
      for (int unsigned i = 0; i < 25; i++)
        step(($urandom_range(99) < 5) ? 1 : 0, {32'($urandom), 32'($urandom)}, did);
    end

    // PC wrap-around at the top of the address space.
    lat = 2; p_rr = 100; p_ir = 100;
    step(1, 64'hFFFF_FFFF_FFFF_FFF6, did);
    run(25);

    // ebreak at 0x80000008, then redirect.
    ebreak_addr = 64'h8000_0008;
    do_reset();
    lat = 1;
    run(20);
    step(1, 64'h8000_0100, did);
    run(20);
    ebreak_addr = '1;

    // Asynchronous reset mid-stream.
    lat = 3;
    wait_pending(2, "reset_two_outstanding");
    do_reset();
    lat = 1;
    run(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
